// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one I2C master among NREQ requesters.
// Latency: req rise in IDLE -> grant and m_newd two cycles later; done/err pulse one cycle after master done or timeout.
// Backpressure: requesters hold req level until their done/err pulse; only one transaction is in flight at a time.
module i2c_txn_arbiter #(
  parameter int NREQ      = 4,
  parameter int NEWD_HOLD = 48,
  parameter int TIMEOUT   = 8192
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [7*NREQ-1:0]    req_addr,
  input  logic [8*NREQ-1:0]    req_wdata,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      req_done,
  output logic [NREQ-1:0]      req_err,
  output logic                 m_newd,
  output logic                 m_wr,
  output logic [6:0]           m_addr,
  output logic [7:0]           m_wdata,
  input  logic                 m_done,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(NEWD_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LAUNCH,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr, rr_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [TW-1:0]   to_cnt, to_nxt;
  logic            m_done_q;
  logic [NREQ-1:0] grant_nxt, done_nxt, err_nxt;
  logic            newd_nxt;
  logic            load;
  logic            found;
  logic [PW-1:0]   win;
  logic            done_edge;

  assign busy      = (state != S_IDLE);
  assign done_edge = m_done & ~m_done_q;

  // Round-robin scan: first requester at or above rr_ptr (mod NREQ) wins.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    done_nxt  = '0;
    err_nxt   = '0;
    newd_nxt  = m_newd;
    hold_nxt  = hold_cnt;
    to_nxt    = to_cnt;
    rr_nxt    = rr_ptr;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req) state_nxt = S_ARB;
      end
      S_ARB: begin
        if (found) begin
          grant_nxt      = '0;
          grant_nxt[win] = 1'b1;
          rr_nxt         = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
          load           = 1'b1;
          newd_nxt       = 1'b1;
          hold_nxt       = '0;
          to_nxt         = '0;
          state_nxt      = S_LAUNCH;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_LAUNCH: begin
        to_nxt = '0;
        if (hold_cnt == HW'(NEWD_HOLD - 1)) begin
          newd_nxt  = 1'b0;
          state_nxt = S_WAIT;
        end else if (hold_cnt != HW'(NEWD_HOLD)) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        // A master done edge takes priority over a coincident timeout.
        if (done_edge) begin
          done_nxt  = grant;
          state_nxt = S_RELEASE;
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          err_nxt   = grant;
          state_nxt = S_RELEASE;
        end else if (to_cnt != TW'(TIMEOUT)) begin
          to_nxt = to_cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        grant_nxt = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        grant_nxt = '0;
        newd_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, counters, registered outputs and latched payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      to_cnt   <= '0;
      m_done_q <= 1'b0;
      grant    <= '0;
      req_done <= '0;
      req_err  <= '0;
      m_newd   <= 1'b0;
      m_wr     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      hold_cnt <= hold_nxt;
      to_cnt   <= to_nxt;
      m_done_q <= m_done;
      grant    <= grant_nxt;
      req_done <= done_nxt;
      req_err  <= err_nxt;
      m_newd   <= newd_nxt;
      if (load) begin
        m_wr    <= req_wr[win];
        m_addr  <= req_addr[7*int'(win) +: 7];
        m_wdata <= req_wdata[8*int'(win) +: 8];
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: reset, launch, done, round-robin, timeout, abort.
// Inputs driven and outputs sampled on the falling clock edge.
// Every wait on the DUT is cycle-bounded.
module tb_i2c_txn_arbiter;

  localparam int NREQ = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req, req_wr;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   grant, req_done, req_err;
  logic              m_newd, m_wr, m_done, busy;
  logic [6:0]        m_addr;
  logic [7:0]        m_wdata;

  int checks   = 0;
  int failures = 0;
  int n;

  i2c_txn_arbiter #(.NREQ(NREQ), .NEWD_HOLD(48), .TIMEOUT(8192)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .req_done(req_done), .req_err(req_err),
    .m_newd(m_newd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_done(m_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) until a grant appears.
  task automatic wait_grant();
    int i = 0;
    while (grant == '0 && i < 20) begin
      @(negedge clk);
      i++;
    end
  endtask

  // Wait (bounded) until the launch strobe drops, i.e. the FSM is in WAIT.
  task automatic wait_launch_end();
    int i = 0;
    while (m_newd && i < 100) begin
      @(negedge clk);
      i++;
    end
  endtask

  // Complete one transaction acknowledged by the master.
  task automatic run_txn(input string tag, input logic [3:0] exp_g, input logic [6:0] exp_a);
    wait_grant();
    chk({tag, "_grant"}, grant, exp_g);
    chk({tag, "_addr"}, m_addr, exp_a);
    wait_launch_end();
    m_done = 1'b1;
    @(negedge clk);
    chk({tag, "_done"}, req_done, exp_g);
    m_done = 1'b0;
    @(negedge clk);
    chk({tag, "_rel"}, grant, 4'b0000);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0; m_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_done", req_done, 0);
    chk("rst_err", req_err, 0);
    chk("rst_newd", m_newd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", {m_wr, m_addr, m_wdata}, 0);
    rst = 1'b0;

    // 1: single write request, grant two cycles after req, newd held 48 cycles
    req = 4'b0001; req_addr[6:0] = 7'h50; req_wdata[7:0] = 8'hA5; req_wr[0] = 1'b1;
    @(negedge clk);
    chk("t1_arb_grant", grant, 0);
    chk("t1_arb_busy", busy, 1);
    @(negedge clk);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_newd", m_newd, 1);
    chk("t1_addr", m_addr, 7'h50);
    chk("t1_wdata", m_wdata, 8'hA5);
    chk("t1_wr", m_wr, 1);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!m_newd) break;
      n++;
    end
    chk("t1_newd_len", n, 48);
    chk("t1_wait_busy", busy, 1);

    // 2: master done edge in WAIT
    m_done = 1'b1;
    @(negedge clk);
    chk("t2_done", req_done, 4'b0001);
    chk("t2_grant_held", grant, 4'b0001);
    m_done = 1'b0; req = '0;
    @(negedge clk);
    chk("t2_done_once", req_done, 0);
    chk("t2_grant_clr", grant, 0);
    chk("t2_busy", busy, 0);

    // 3: all requesting, round-robin with wrap (rr_ptr back to 0 via reset)
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      req_addr[7*k +: 7]  = 7'(7'h10 + k);
      req_wdata[8*k +: 8] = 8'(8'h30 + k);
    end
    req = 4'b1111;
    run_txn("t3_0", 4'b0001, 7'h10);
    run_txn("t3_1", 4'b0010, 7'h11);
    run_txn("t3_2", 4'b0100, 7'h12);
    run_txn("t3_3", 4'b1000, 7'h13);
    run_txn("t3_4", 4'b0001, 7'h10);

    // 4: drive rr_ptr to 2, then req=0011 scans 2,3,0 -> requester 0
    req = 4'b0010;
    run_txn("t4_a", 4'b0010, 7'h11);
    req = 4'b0011;
    run_txn("t4_b", 4'b0001, 7'h10);
    run_txn("t4_c", 4'b0010, 7'h11);

    // 5: timeout after 8192 WAIT cycles, late m_done in IDLE ignored
    req = 4'b0100;
    wait_grant();
    chk("t5_grant", grant, 4'b0100);
    wait_launch_end();
    repeat (8191) @(negedge clk);
    chk("t5_no_err_early", req_err, 0);
    chk("t5_still_busy", busy, 1);
    @(negedge clk);
    chk("t5_err", req_err, 4'b0100);
    chk("t5_no_done", req_done, 0);
    req = '0;
    @(negedge clk);
    chk("t5_err_once", req_err, 0);
    chk("t5_idle", busy, 0);
    m_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_late_done", req_done, 0);
    chk("t5_late_busy", busy, 0);
    m_done = 1'b0;
    @(negedge clk);

    // 6a: reset in WAIT aborts silently
    req = 4'b0001;
    wait_grant();
    chk("t6_grant", grant, 4'b0001);
    wait_launch_end();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_grant_clr", grant, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pulses", {req_done, req_err}, 0);
    rst = 1'b0; req = '0;
    @(negedge clk);
    chk("t6_after_pulses", {req_done, req_err}, 0);

    // 6b: m_done during LAUNCH ignored; req dropped mid-transaction still gets done
    req = 4'b0010;
    wait_grant();
    chk("t6b_grant", grant, 4'b0010);
    m_done = 1'b1;
    req = '0;
    wait_launch_end();
    repeat (3) @(negedge clk);
    chk("t6b_no_done", req_done, 0);
    chk("t6b_busy", busy, 1);
    m_done = 1'b0;
    @(negedge clk);
    m_done = 1'b1;
    @(negedge clk);
    chk("t6b_done", req_done, 4'b0010);
    m_done = 1'b0;
    @(negedge clk);
    chk("t6b_rel", grant, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
